axis_joiner: RTL and testbench

AXIS_JOINER -- requirements
Module: axis_joiner

---
 rtl/axis_joiner_pkg.sv | 23 ++
 rtl/axis_joiner_if.sv | 11 +
 rtl/axis_joiner_slot.sv | 39 +++
 rtl/axis_joiner.sv | 106 ++++++++++
 tb/tb_axis_joiner.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_joiner_pkg.sv
// Shared constants and placement helpers for the three-slot AXI-Stream joiner.
package axis_joiner_pkg;

    localparam int unsigned C_NUM_SLOTS      = 3;
    localparam int unsigned C_DEF_M_WIDTH    = 240;
    localparam int unsigned C_DEF_S00_WIDTH  = 96;
    localparam int unsigned C_DEF_S01_WIDTH  = 72;
    localparam int unsigned C_DEF_S02_WIDTH  = 72;
    localparam int unsigned C_DEF_S00_LSB    = 0;
    localparam int unsigned C_DEF_S01_LSB    = 96;
    localparam int unsigned C_DEF_S02_LSB    = 168;

    function automatic bit ranges_disjoint(input int unsigned lsb_a, input int unsigned w_a,
                                           input int unsigned lsb_b, input int unsigned w_b);
        return ((lsb_a + w_a) <= lsb_b) || ((lsb_b + w_b) <= lsb_a);
    endfunction

    function automatic bit slot_fits(input int unsigned lsb, input int unsigned w,
                                     input int unsigned total);
        return (lsb + w) <= total;
    endfunction

endpackage

// File: rtl/axis_joiner_if.sv
// Minimal AXI-Stream channel (valid/ready/data) with producer and consumer views.
interface axis_joiner_if #(
    parameter int unsigned TDATA_WIDTH = 8
);
    logic                   tvalid;
    logic                   tready;
    logic [TDATA_WIDTH-1:0] tdata;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axis_joiner_slot.sv
// One input slot: single-beat holding register with a full flag.
module axis_joiner_slot
    import axis_joiner_pkg::*;
#(
    parameter int unsigned C_WIDTH = C_DEF_S00_WIDTH
)(
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               i_valid,
    input  logic [C_WIDTH-1:0] i_data,
    input  logic               i_join_fire,
    output logic               o_ready,
    output logic               o_full,
    output logic [C_WIDTH-1:0] o_data
);

    logic               r_full;
    logic [C_WIDTH-1:0] r_data;
    logic               w_hs;

    // A firing join frees the slot this cycle, so a new beat can replace the old one.
    assign o_ready = aresetn & (~r_full | i_join_fire);
    assign w_hs    = i_valid & o_ready;
    assign o_full  = r_full;
    assign o_data  = r_data;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (w_hs) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end else if (i_join_fire) begin
            r_full <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_joiner.sv
// Joins one beat from each of three AXI-Stream inputs into one wide output beat.
module axis_joiner
    import axis_joiner_pkg::*;
#(
    parameter int unsigned C_M_AXIS_TDATA_WIDTH   = C_DEF_M_WIDTH,
    parameter int unsigned C_NUM_SI_SLOTS         = C_NUM_SLOTS,
    parameter int unsigned C_S00_AXIS_TDATA_WIDTH = C_DEF_S00_WIDTH,
    parameter int unsigned C_S01_AXIS_TDATA_WIDTH = C_DEF_S01_WIDTH,
    parameter int unsigned C_S02_AXIS_TDATA_WIDTH = C_DEF_S02_WIDTH,
    parameter int unsigned C_S00_AXIS_TDATA_LSB   = C_DEF_S00_LSB,
    parameter int unsigned C_S01_AXIS_TDATA_LSB   = C_DEF_S01_LSB,
    parameter int unsigned C_S02_AXIS_TDATA_LSB   = C_DEF_S02_LSB
)(
    input  logic                aclk,
    input  logic                aresetn,
    axis_joiner_if.slave        s00_axis,
    axis_joiner_if.slave        s01_axis,
    axis_joiner_if.slave        s02_axis,
    axis_joiner_if.master       m_axis,
    output logic [31:0]         join_count
);

    if (C_NUM_SI_SLOTS != C_NUM_SLOTS) begin : g_err_slots
        $error("axis_joiner: C_NUM_SI_SLOTS must be 3");
    end
    if (!slot_fits(C_S00_AXIS_TDATA_LSB, C_S00_AXIS_TDATA_WIDTH, C_M_AXIS_TDATA_WIDTH) ||
        !slot_fits(C_S01_AXIS_TDATA_LSB, C_S01_AXIS_TDATA_WIDTH, C_M_AXIS_TDATA_WIDTH) ||
        !slot_fits(C_S02_AXIS_TDATA_LSB, C_S02_AXIS_TDATA_WIDTH, C_M_AXIS_TDATA_WIDTH)) begin : g_err_fit
        $error("axis_joiner: slot range exceeds output width");
    end
    if (!ranges_disjoint(C_S00_AXIS_TDATA_LSB, C_S00_AXIS_TDATA_WIDTH,
                         C_S01_AXIS_TDATA_LSB, C_S01_AXIS_TDATA_WIDTH) ||
        !ranges_disjoint(C_S00_AXIS_TDATA_LSB, C_S00_AXIS_TDATA_WIDTH,
                         C_S02_AXIS_TDATA_LSB, C_S02_AXIS_TDATA_WIDTH) ||
        !ranges_disjoint(C_S01_AXIS_TDATA_LSB, C_S01_AXIS_TDATA_WIDTH,
                         C_S02_AXIS_TDATA_LSB, C_S02_AXIS_TDATA_WIDTH)) begin : g_err_overlap
        $error("axis_joiner: slot ranges overlap");
    end

    logic [2:0]                        w_full;
    logic                              w_ready00, w_ready01, w_ready02;
    logic [C_S00_AXIS_TDATA_WIDTH-1:0] w_data00;
    logic [C_S01_AXIS_TDATA_WIDTH-1:0] w_data01;
    logic [C_S02_AXIS_TDATA_WIDTH-1:0] w_data02;
    logic [C_M_AXIS_TDATA_WIDTH-1:0]   w_joined;
    logic                              w_join_fire;
    logic                              w_m_hs;

    logic                              r_m_tvalid;
    logic [C_M_AXIS_TDATA_WIDTH-1:0]   r_m_tdata;
    logic [31:0]                       r_join_count;

    assign w_join_fire = (&w_full) & (~r_m_tvalid | m_axis.tready);
    assign w_m_hs      = r_m_tvalid & m_axis.tready;

    axis_joiner_slot #(.C_WIDTH(C_S00_AXIS_TDATA_WIDTH)) u_slot00 (
        .aclk(aclk), .aresetn(aresetn),
        .i_valid(s00_axis.tvalid), .i_data(s00_axis.tdata), .i_join_fire(w_join_fire),
        .o_ready(w_ready00), .o_full(w_full[0]), .o_data(w_data00)
    );
    axis_joiner_slot #(.C_WIDTH(C_S01_AXIS_TDATA_WIDTH)) u_slot01 (
        .aclk(aclk), .aresetn(aresetn),
        .i_valid(s01_axis.tvalid), .i_data(s01_axis.tdata), .i_join_fire(w_join_fire),
        .o_ready(w_ready01), .o_full(w_full[1]), .o_data(w_data01)
    );
    axis_joiner_slot #(.C_WIDTH(C_S02_AXIS_TDATA_WIDTH)) u_slot02 (
        .aclk(aclk), .aresetn(aresetn),
        .i_valid(s02_axis.tvalid), .i_data(s02_axis.tdata), .i_join_fire(w_join_fire),
        .o_ready(w_ready02), .o_full(w_full[2]), .o_data(w_data02)
    );

    assign s00_axis.tready = w_ready00;
    assign s01_axis.tready = w_ready01;
    assign s02_axis.tready = w_ready02;

    // Bits outside every slot range stay zero.
    always_comb begin
        w_joined = '0;
        w_joined[C_S00_AXIS_TDATA_LSB +: C_S00_AXIS_TDATA_WIDTH] = w_data00;
        w_joined[C_S01_AXIS_TDATA_LSB +: C_S01_AXIS_TDATA_WIDTH] = w_data01;
        w_joined[C_S02_AXIS_TDATA_LSB +: C_S02_AXIS_TDATA_WIDTH] = w_data02;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_m_tvalid   <= 1'b0;
            r_m_tdata    <= '0;
            r_join_count <= '0;
        end else begin
            if (w_join_fire) begin
                r_m_tvalid <= 1'b1;
                r_m_tdata  <= w_joined;
            end else if (w_m_hs) begin
                r_m_tvalid <= 1'b0;
            end
            if (w_m_hs) begin
                r_join_count <= r_join_count + 32'd1;
            end
        end
    end

    assign m_axis.tvalid = r_m_tvalid;
    assign m_axis.tdata  = r_m_tdata;
    assign join_count    = r_join_count;

endmodule

// File: tb/tb_axis_joiner.sv
// Directed bench for axis_joiner: vector table plus hand-written multi-cycle sequences.
module tb_axis_joiner;

    logic        aclk;
    logic        aresetn;
    logic [31:0] join_count;

    axis_joiner_if #(.TDATA_WIDTH(96))  s00_if();
    axis_joiner_if #(.TDATA_WIDTH(72))  s01_if();
    axis_joiner_if #(.TDATA_WIDTH(72))  s02_if();
    axis_joiner_if #(.TDATA_WIDTH(240)) m_if();

    axis_joiner #(
        .C_M_AXIS_TDATA_WIDTH(240), .C_NUM_SI_SLOTS(3),
        .C_S00_AXIS_TDATA_WIDTH(96), .C_S01_AXIS_TDATA_WIDTH(72), .C_S02_AXIS_TDATA_WIDTH(72),
        .C_S00_AXIS_TDATA_LSB(0), .C_S01_AXIS_TDATA_LSB(96), .C_S02_AXIS_TDATA_LSB(168)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s00_axis(s00_if.slave), .s01_axis(s01_if.slave), .s02_axis(s02_if.slave),
        .m_axis(m_if.master), .join_count(join_count)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [2:0]  v;      // {s02, s01, s00} tvalid
        logic [3:0]  a, b, c;
        logic        mr;
        logic [2:0]  rdy;    // expected {s02, s01, s00} tready
        logic        mv;
        logic [3:0]  ea, eb, ec;
        logic [31:0] cnt;
    } vec_t;

    vec_t tbl[15];

    function automatic vec_t mk(input logic [2:0] v, input logic [3:0] a, b, c, input logic mr,
                                input logic [2:0] rdy, input logic mv,
                                input logic [3:0] ea, eb, ec, input logic [31:0] cnt);
        vec_t r;
        r.v = v; r.a = a; r.b = b; r.c = c; r.mr = mr; r.rdy = rdy; r.mv = mv;
        r.ea = ea; r.eb = eb; r.ec = ec; r.cnt = cnt;
        return r;
    endfunction

    function automatic logic [239:0] beat(input logic [3:0] a, b, c);
        return {{18{c}}, {18{b}}, {24{a}}};
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs just after an edge and let combinational outputs settle.
    task automatic apply(input logic [2:0] v, input logic [3:0] a, b, c, input logic mr);
        s00_if.tvalid = v[0]; s00_if.tdata = {24{a}};
        s01_if.tvalid = v[1]; s01_if.tdata = {18{b}};
        s02_if.tvalid = v[2]; s02_if.tdata = {18{c}};
        m_if.tready   = mr;
        #2;
    endtask

    task automatic next_cycle();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [2:0] rdy_vec();
        return {s02_if.tready, s01_if.tready, s00_if.tready};
    endfunction

    function automatic logic [2:0] full_vec();
        return {dut.u_slot02.r_full, dut.u_slot01.r_full, dut.u_slot00.r_full};
    endfunction

    logic [239:0] q[$];
    logic [239:0] exp_beat;
    int beats, gaps, rdy_bad;
    bit started;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = mk(3'b111, 4'hA, 4'hB, 4'hC, 1, 3'b111, 0, 0, 0, 0, 0);
        tbl[1]  = mk(3'b000, 0, 0, 0, 1, 3'b111, 0, 0, 0, 0, 0);
        tbl[2]  = mk(3'b000, 0, 0, 0, 1, 3'b111, 1, 4'hA, 4'hB, 4'hC, 0);
        tbl[3]  = mk(3'b000, 0, 0, 0, 1, 3'b111, 0, 0, 0, 0, 1);
        tbl[4]  = mk(3'b100, 0, 0, 3, 1, 3'b111, 0, 0, 0, 0, 1);
        tbl[5]  = mk(3'b000, 0, 0, 0, 1, 3'b011, 0, 0, 0, 0, 1);
        tbl[6]  = mk(3'b000, 0, 0, 0, 1, 3'b011, 0, 0, 0, 0, 1);
        tbl[7]  = mk(3'b001, 1, 0, 0, 1, 3'b011, 0, 0, 0, 0, 1);
        tbl[8]  = mk(3'b000, 0, 0, 0, 1, 3'b010, 0, 0, 0, 0, 1);
        tbl[9]  = mk(3'b000, 0, 0, 0, 1, 3'b010, 0, 0, 0, 0, 1);
        tbl[10] = mk(3'b000, 0, 0, 0, 1, 3'b010, 0, 0, 0, 0, 1);
        tbl[11] = mk(3'b010, 0, 2, 0, 1, 3'b010, 0, 0, 0, 0, 1);
        tbl[12] = mk(3'b000, 0, 0, 0, 1, 3'b111, 0, 0, 0, 0, 1);
        tbl[13] = mk(3'b000, 0, 0, 0, 1, 3'b111, 1, 1, 2, 3, 1);
        tbl[14] = mk(3'b000, 0, 0, 0, 1, 3'b111, 0, 0, 0, 0, 2);

        // Reset with inputs valid: nothing may be accepted.
        aresetn = 1'b0;
        apply(3'b111, 4'h5, 4'h5, 4'h5, 1);
        next_cycle();
        next_cycle();
        apply(3'b111, 4'h5, 4'h5, 4'h5, 1);
        check("reset_tready", 256'(rdy_vec()), 256'(3'b000));
        check("reset_tvalid", 256'(m_if.tvalid), 256'(1'b0));
        check("reset_tdata", 256'(m_if.tdata), 256'(0));
        check("reset_count", 256'(join_count), 256'(0));
        check("reset_full", 256'(full_vec()), 256'(3'b000));
        next_cycle();
        aresetn = 1'b1;

        // Same-cycle join, then out-of-order arrival.
        foreach (tbl[i]) begin
            apply(tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].mr);
            check($sformatf("tbl%0d_tready", i), 256'(rdy_vec()), 256'(tbl[i].rdy));
            check($sformatf("tbl%0d_tvalid", i), 256'(m_if.tvalid), 256'(tbl[i].mv));
            check($sformatf("tbl%0d_count", i), 256'(join_count), 256'(tbl[i].cnt));
            if (tbl[i].mv) begin
                exp_beat = beat(tbl[i].ea, tbl[i].eb, tbl[i].ec);
                check($sformatf("tbl%0d_tdata", i), 256'(m_if.tdata), 256'(exp_beat));
            end
            next_cycle();
        end

        // Sustained throughput with a scoreboard.
        beats = 0; gaps = 0; rdy_bad = 0; started = 0;
        for (int k = 0; k < 100; k++) begin
            apply(3'b111, 4'(k), 4'(k + 5), 4'(k + 9), 1);
            if (rdy_vec() !== 3'b111) rdy_bad++;
            if (m_if.tvalid === 1'b1) begin
                started = 1;
                beats++;
                exp_beat = (q.size() > 0) ? q.pop_front() : '0;
                check("tput_data", 256'(m_if.tdata), 256'(exp_beat));
            end else if (started) begin
                gaps++;
            end
            q.push_back(beat(4'(k), 4'(k + 5), 4'(k + 9)));
            next_cycle();
        end
        check("tput_beats_in_window", 256'(beats), 256'(98));
        check("tput_gaps", 256'(gaps), 256'(0));
        check("tput_tready", 256'(rdy_bad), 256'(0));
        for (int k = 0; k < 3; k++) begin
            apply(3'b000, 0, 0, 0, 1);
            if (m_if.tvalid === 1'b1) begin
                beats++;
                exp_beat = (q.size() > 0) ? q.pop_front() : '0;
                check("drain_data", 256'(m_if.tdata), 256'(exp_beat));
            end
            if (k < 2) next_cycle();
        end
        check("drain_beats", 256'(beats), 256'(100));
        check("drain_queue_empty", 256'(q.size()), 256'(0));
        check("drain_tvalid", 256'(m_if.tvalid), 256'(1'b0));
        check("tput_count", 256'(join_count), 256'(102));
        next_cycle();

        // Backpressure: output held while a second set of beats waits in the slots.
        apply(3'b111, 1, 2, 3, 0);
        check("bp_c0_tready", 256'(rdy_vec()), 256'(3'b111));
        next_cycle();
        apply(3'b111, 4, 5, 6, 0);
        check("bp_c1_tready", 256'(rdy_vec()), 256'(3'b111));
        check("bp_c1_tvalid", 256'(m_if.tvalid), 256'(1'b0));
        next_cycle();
        for (int k = 0; k < 10; k++) begin
            apply(3'b111, 7, 8, 9, 0);
            check("bp_hold_tvalid", 256'(m_if.tvalid), 256'(1'b1));
            check("bp_hold_tdata", 256'(m_if.tdata), 256'(beat(1, 2, 3)));
            check("bp_hold_tready", 256'(rdy_vec()), 256'(3'b000));
            check("bp_hold_full", 256'(full_vec()), 256'(3'b111));
            next_cycle();
        end
        apply(3'b000, 0, 0, 0, 1);
        check("bp_rel_tdata1", 256'(m_if.tdata), 256'(beat(1, 2, 3)));
        check("bp_rel_tready", 256'(rdy_vec()), 256'(3'b111));
        next_cycle();
        apply(3'b000, 0, 0, 0, 1);
        check("bp_rel_tvalid2", 256'(m_if.tvalid), 256'(1'b1));
        check("bp_rel_tdata2", 256'(m_if.tdata), 256'(beat(4, 5, 6)));
        next_cycle();
        apply(3'b000, 0, 0, 0, 1);
        check("bp_end_tvalid", 256'(m_if.tvalid), 256'(1'b0));
        check("bp_end_count", 256'(join_count), 256'(104));
        next_cycle();

        // One-cycle reset with held slots and a pending output beat.
        apply(3'b111, 4'hD, 4'hD, 4'hD, 0);
        next_cycle();
        apply(3'b011, 4'hE, 4'hE, 0, 0);
        check("rst_mid_c1_tready", 256'(rdy_vec()), 256'(3'b111));
        next_cycle();
        apply(3'b011, 4'hE, 4'hE, 0, 0);
        check("rst_mid_tvalid_before", 256'(m_if.tvalid), 256'(1'b1));
        check("rst_mid_tready_before", 256'(rdy_vec()), 256'(3'b100));
        aresetn = 1'b0;
        #1;
        check("rst_mid_tready_gated", 256'(rdy_vec()), 256'(3'b000));
        next_cycle();
        aresetn = 1'b1;
        apply(3'b100, 0, 0, 4'hF, 1);
        check("rst_mid_tvalid_after", 256'(m_if.tvalid), 256'(1'b0));
        check("rst_mid_count_after", 256'(join_count), 256'(0));
        check("rst_mid_full_after", 256'(full_vec()), 256'(3'b000));
        check("rst_first_cycle_tready", 256'(rdy_vec()), 256'(3'b111));
        next_cycle();
        for (int k = 0; k < 4; k++) begin
            apply(3'b000, 0, 0, 0, 1);
            check("rst_no_spurious", 256'(m_if.tvalid), 256'(1'b0));
            next_cycle();
        end
        aresetn = 1'b0;
        next_cycle();
        aresetn = 1'b1;

        // Counter wrap from a preloaded value.
        force dut.r_join_count = 32'hFFFF_FFFE;
        #1;
        release dut.r_join_count;
        apply(3'b111, 1, 2, 3, 1);
        check("wrap_preload", 256'(join_count), 256'(32'hFFFF_FFFE));
        next_cycle();
        apply(3'b111, 2, 3, 4, 1);
        next_cycle();
        apply(3'b111, 3, 4, 5, 1);
        check("wrap_c2_count", 256'(join_count), 256'(32'hFFFF_FFFE));
        next_cycle();
        apply(3'b000, 0, 0, 0, 1);
        check("wrap_count_ffffffff", 256'(join_count), 256'(32'hFFFF_FFFF));
        next_cycle();
        apply(3'b000, 0, 0, 0, 1);
        check("wrap_count_0", 256'(join_count), 256'(0));
        check("wrap_last_tdata", 256'(m_if.tdata), 256'(beat(3, 4, 5)));
        next_cycle();
        apply(3'b000, 0, 0, 0, 1);
        check("wrap_count_1", 256'(join_count), 256'(1));
        check("wrap_end_tvalid", 256'(m_if.tvalid), 256'(1'b0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
